// File: rtl/bus_seq_if.sv
// Handshake and register-file control bundle for bus_seq.
// master = instruction source, slave = the sequencer.
interface bus_seq_if #(
    parameter int IW = 2
);
    localparam int NREG = 2**IW;

    logic            in_valid;
    logic            in_ready;
    logic [7:0]      instr;
    logic [NREG-1:0] rs;
    logic [NREG-1:0] ws;
    logic [NREG-1:0] lrst;
    logic            op_rs;
    logic            op_ws;
    logic [3:0]      imm_out;
    logic            done;
    logic            err;

    modport master (
        output in_valid, instr,
        input  in_ready, rs, ws, lrst,
        input  op_rs, op_ws, imm_out, done, err
    );

    modport slave (
        input  in_valid, instr,
        output in_ready, rs, ws, lrst,
        output op_rs, op_ws, imm_out, done, err
    );
endinterface

// File: rtl/bus_seq.sv
// Register-transfer sequencer for the shared tristate data bus.
// Expands one latched instruction into registered per-step strobes.
module bus_seq #(
    parameter int IW  = 2,
    parameter int TMP = 2**IW-1
) (
    input logic    clk,
    input logic    grst,
    bus_seq_if.slave bus
);
    localparam int NREG = 2**IW;
    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_SWP = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;
    localparam logic [IW-1:0] TMPI = IW'(TMP);

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    state_t state, nxt;
    logic [7:0] ir, nxt_ir;

    logic [1:0]    op;
    logic [IW-1:0] dst, src;
    logic [3:0]    imm;
    logic          same, bad;

    logic [NREG-1:0] rs_d, ws_d, lrst_d;
    logic            op_rs_d, op_ws_d, done_d, err_d;
    logic [3:0]      imm_d;

    logic [NREG-1:0] rs_q, ws_q, lrst_q;
    logic            op_rs_q, op_ws_q, done_q, err_q, rdy_q;
    logic [3:0]      imm_q;

    function automatic logic [NREG-1:0] oh(input logic [IW-1:0] i);
        oh    = '0;
        oh[i] = 1'b1;
    endfunction

    // Outputs are decoded from the instruction that will be held next
    // cycle, so the accept edge already presents T1 strobes.
    always_comb begin
        nxt_ir = ir;
        if (state == IDLE && bus.in_valid)
            nxt_ir = bus.instr;
    end

    assign op   = nxt_ir[7:6];
    assign dst  = IW'(nxt_ir[5:4]);
    assign src  = nxt_ir[IW-1:0];
    assign imm  = nxt_ir[3:0];
    assign same = (dst == src);
    assign bad  = !same && (dst == TMPI || src == TMPI);

    always_comb begin
        nxt     = state;
        rs_d    = '0;
        ws_d    = '0;
        lrst_d  = '0;
        op_rs_d = 1'b0;
        op_ws_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        imm_d   = 4'd0;

        case (state)
            IDLE: if (bus.in_valid) nxt = T1;
            T1: begin
                if (op == OP_LDI || (op == OP_SWP && !same && !bad))
                    nxt = T2;
                else
                    nxt = IDLE;
            end
            T2:      nxt = (op == OP_SWP) ? T3 : IDLE;
            default: nxt = IDLE;
        endcase

        if (nxt != IDLE) begin
            unique case (1'b1)
                op == OP_MOV: begin
                    done_d = 1'b1;
                    if (!same) begin
                        ws_d = oh(src);
                        rs_d = oh(dst);
                    end
                end
                op == OP_LDI: begin
                    imm_d = imm;
                    if (nxt == T1) begin
                        op_rs_d = 1'b1;
                    end else begin
                        op_ws_d = 1'b1;
                        rs_d    = oh(dst);
                        done_d  = 1'b1;
                    end
                end
                op == OP_CLR: begin
                    lrst_d = oh(dst);
                    done_d = 1'b1;
                end
                op == OP_SWP: begin
                    if (same) begin
                        done_d = 1'b1;
                    end else if (bad) begin
                        err_d = 1'b1;
                    end else begin
                        case (nxt)
                            T1: begin
                                ws_d = oh(dst);
                                rs_d = oh(TMPI);
                            end
                            T2: begin
                                ws_d = oh(src);
                                rs_d = oh(dst);
                            end
                            T3: begin
                                ws_d   = oh(TMPI);
                                rs_d   = oh(src);
                                done_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            state <= IDLE;
            ir    <= 8'd0;
        end else begin
            state <= nxt;
            ir    <= nxt_ir;
        end
    end

    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            rs_q    <= '0;
            ws_q    <= '0;
            lrst_q  <= '0;
            op_rs_q <= 1'b0;
            op_ws_q <= 1'b0;
            imm_q   <= 4'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            rs_q    <= rs_d;
            ws_q    <= ws_d;
            lrst_q  <= lrst_d;
            op_rs_q <= op_rs_d;
            op_ws_q <= op_ws_d;
            imm_q   <= imm_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdy_q   <= (nxt == IDLE);
        end
    end

    assign bus.rs       = rs_q;
    assign bus.ws       = ws_q;
    assign bus.lrst     = lrst_q;
    assign bus.op_rs    = op_rs_q;
    assign bus.op_ws    = op_ws_q;
    assign bus.imm_out  = imm_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.in_ready = rdy_q;
endmodule

// File: tb/tb_bus_seq.sv
// Directed and random-stream bench for bus_seq with a register-file
// model that latches the bus from the sequencer strobes.
module tb_bus_seq;
    logic clk  = 1'b0;
    logic grst = 1'b0;
    always #5 clk = ~clk;

    bus_seq_if #(.IW(2)) bif();

    bus_seq #(.IW(2), .TMP(3)) dut (
        .clk  (clk),
        .grst (grst),
        .bus  (bif.slave)
    );

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    logic [3:0] rf [4] = '{default: 4'd0};
    logic [3:0] opr    = 4'd0;
    logic [3:0] m  [4];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(
        input logic [3:0] r, input logic [3:0] w, input logic [3:0] l,
        input logic ors, input logic ows, input logic [3:0] im,
        input logic dn, input logic er, input logic rdy);
        return {11'd0, rdy, er, dn, ows, ors, im, l, w, r};
    endfunction

    function automatic logic [31:0] obs();
        return pk(bif.rs, bif.ws, bif.lrst, bif.op_rs, bif.op_ws,
                  bif.imm_out, bif.done, bif.err, bif.in_ready);
    endfunction

    task automatic expo(input string tag, input logic [31:0] e);
        chk(tag, obs(), e);
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!bif.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bif.in_ready)
            chk("ready_timeout", {31'd0, bif.in_ready}, 32'd1);
    endtask

    // Returns at the falling edge inside T1 of the accepted instruction.
    task automatic issue(input logic [7:0] ins);
        @(negedge clk);
        wait_rdy();
        bif.instr    = ins;
        bif.in_valid = 1'b1;
        @(negedge clk);
        bif.in_valid = 1'b0;
    endtask

    // Register file behind the tristate bus, plus invariant watch.
    always @(negedge clk) begin
        logic [3:0] b;
        b = 4'd0;
        if ($countones(bif.ws) + int'(bif.op_ws) > 1) viol++;
        if ($countones(bif.rs) > 1) viol++;
        if ((bif.rs & bif.ws) != 4'd0) viol++;
        if (bif.lrst != 4'd0 && (bif.rs | bif.ws) != 4'd0) viol++;
        if (bif.imm_out != 4'd0 && !(bif.op_rs || bif.op_ws)) viol++;
        for (int k = 0; k < 4; k++)
            if (bif.ws[k]) b = rf[k];
        if (bif.op_ws) b = opr;
        for (int k = 0; k < 4; k++) begin
            if (bif.lrst[k]) rf[k] <= 4'd0;
            else if (bif.rs[k]) rf[k] <= b;
        end
        if (bif.op_rs) opr <= bif.imm_out;
    end

    logic [31:0] idl;

    initial begin
        logic [7:0] ins;
        logic [1:0] d, s;
        logic [3:0] t;
        bif.in_valid = 1'b0;
        bif.instr    = 8'd0;
        idl = pk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        #2 grst = 1'b1;
        #1 expo("rst_async", idl);
        repeat (2) @(negedge clk);
        grst = 1'b0;

        issue(8'h6A);
        expo("ldi_t1", pk(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        expo("ldi_t2", pk(4'b0100, 4'd0, 4'd0, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        expo("ldi_idle", idl);
        chk("ldi_r2", 32'(rf[2]), 32'hA);

        issue(8'h10);
        expo("mov_t1", pk(4'b0010, 4'b0001, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        expo("mov_idle", idl);

        issue(8'h11);
        expo("mov_same", pk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0));

        issue(8'h81);
        expo("swp_t1", pk(4'b1000, 4'b0001, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        expo("swp_t2", pk(4'b0001, 4'b0010, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        expo("swp_t3", pk(4'b0010, 4'b1000, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0));

        issue(8'hB0);
        expo("swp_ill", pk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));

        issue(8'hF0);
        expo("clr_t1", pk(4'd0, 4'd0, 4'b1000, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        expo("clr_idle", idl);

        bif.instr    = 8'h45;
        bif.in_valid = 1'b1;
        @(negedge clk);
        bif.instr = 8'h10;
        expo("hold_t1", pk(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        expo("hold_t2", pk(4'b0001, 4'd0, 4'd0, 1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        expo("hold_idle", idl);
        bif.in_valid = 1'b0;

        issue(8'h81);
        expo("abort_t1", pk(4'b1000, 4'b0001, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        expo("abort_t2", pk(4'b0001, 4'b0010, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        grst = 1'b1;
        #1 expo("rst_mid", idl);
        @(negedge clk);
        grst = 1'b0;
        issue(8'h10);
        expo("post_rst_mov", pk(4'b0010, 4'b0001, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0));

        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) m[k] = rf[k];

        for (int i = 0; i < 1000; i++) begin
            ins = 8'($urandom);
            d   = ins[5:4];
            s   = ins[1:0];
            case (ins[7:6])
                2'b00: m[d] = m[s];
                2'b01: m[d] = ins[3:0];
                2'b10: if (d != s && d != 2'd3 && s != 2'd3) begin
                    t    = m[d];
                    m[d] = m[s];
                    m[s] = t;
                    m[3] = t;
                end
                default: m[d] = 4'd0;
            endcase
            issue(ins);
        end
        @(negedge clk);
        wait_rdy();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rand_r%0d", k), 32'(rf[k]), 32'(m[k]));
        chk("invariants", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
